serial_tx: RTL and testbench
============================

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per serial bit (legal range 2..65535).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port tx_valid  input  1  parallel word offered.
REQ-006 SHALL have port tx_data  input  DATA_W  parallel word to serialize.
REQ-007 SHALL have port tx_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port tx  output  1  serial line, idle high.
REQ-009 SHALL have port tx_done  output  1  one-cycle pulse at frame end.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-011 SHALL assert tx_ready only in IDLE.
REQ-012 SHALL accept a word on a rising edge where tx_valid=1 and tx_ready=1, latching tx_data into an internal shift register and entering START.
REQ-013 SHALL ignore tx_valid while tx_ready=0; no queuing, no error flag.
REQ-014 SHALL ignore tx_data changes after acceptance.
REQ-015 SHALL drive tx from a register: first start-bit cycle is the cycle after acceptance.
REQ-016 SHALL hold tx=0 for CLKS_PER_BIT cycles in START.
REQ-017 SHALL send DATA_W data bits LSB first in DATA, each held CLKS_PER_BIT cycles.
REQ-018 SHALL hold tx=1 for CLKS_PER_BIT cycles in STOP, then return to IDLE.
REQ-019 SHALL make a frame exactly (DATA_W+2)*CLKS_PER_BIT cycles from first start-bit cycle to last stop-bit cycle inclusive.
REQ-020 SHALL pulse tx_done high for exactly one cycle, coincident with the last stop-bit cycle.
REQ-021 SHALL assert tx_ready in the cycle after the last stop-bit cycle; back-to-back frames therefore have no extra idle bit beyond the stop bit when tx_valid is held high.
REQ-022 SHALL hold tx=1 in IDLE.
REQ-023 SHALL use a bit-period counter of width clog2(CLKS_PER_BIT) and a bit index counter of width clog2(DATA_W+1); both clear on every state entry, no wrap beyond terminal count.

Reset
REQ-024 SHALL, while rst_n=0, force state=IDLE, tx=1, tx_ready=1, tx_done=0, counters=0, shift register=0, independent of clk.
REQ-025 SHALL abort any frame in progress on reset assertion with tx returning high immediately; no partial-frame completion after release.
REQ-026 SHALL accept a word on the first rising edge after rst_n deasserts if tx_valid=1.

Structure
REQ-027 SHALL place the state enum typedef (IDLE, START, DATA, STOP) in shared package serial_pkg alongside default DATA_W and CLKS_PER_BIT constants.
REQ-028 SHALL instantiate one sub-module, bit_tick_gen, producing a one-cycle tick every CLKS_PER_BIT cycles, restartable by a clear input.
REQ-029 SHALL be 120-400 lines of RTL, all outputs registered.

Verification
REQ-030 Reset: rst_n=0 mid-frame with tx=0 -> tx=1, tx_ready=1, tx_done=0 in same cycle, no clock needed.
REQ-031 Single frame: DATA_W=8, CLKS_PER_BIT=4, tx_data=0xA5 one-cycle valid -> tx sequence per 4 cycles 0,1,0,1,0,0,1,0,1,1; tx_done on cycle 40; tx_ready on cycle 41.
REQ-032 Back-to-back: tx_valid held high, words 0x00 then 0xFF -> two 40-cycle frames, second start bit immediately after first stop bit, two tx_done pulses 41 cycles apart.
REQ-033 Ignored stimulus: tx_valid pulsed and tx_data changed to 0x3C during frame of 0x81 -> line shows only 0x81 frame, returns idle, tx_ready=1.
REQ-034 Reset mid-operation: rst_n low for 2 cycles during bit 3 of 0x55, then 0x0F offered after release -> clean 0x0F frame, no residue of 0x55.
REQ-035 Parameter sweep: CLKS_PER_BIT=2 and 16, DATA_W=5, data 0x15 -> frame lengths 14 and 112 cycles, correct LSB-first bits.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: shared FSM state type and default frame parameters for serial_tx
package serial_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CLKS_PER_BIT = 4;
endpackage

// File: rtl/serial_tx_bit_tick_gen.sv
// bit_tick_gen: bit-period counter giving a tick on the last cycle of each period, plus a one-cycle-early flag
module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick,
  output logic near
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  assign near = cnt == CW'(CLKS_PER_BIT - 2);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clear || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/serial_tx.sv
// serial_tx: parallel-in, LSB-first serial transmitter with start/stop framing and registered outputs
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx,
  output logic              tx_done
);
  localparam int BW = $clog2(DATA_W + 1);
  state_t state, ns;
  logic [DATA_W-1:0] sh;
  logic [BW-1:0] bidx;
  logic tick, near, clear, last_bit, tx_n, done_n;
  bit_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk(clk), .rst_n(rst_n), .clear(clear), .tick(tick), .near(near)
  );
  assign last_bit = bidx == BW'(DATA_W - 1);
  assign clear = ns != state || state == IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tx <= 1'b1;
      tx_ready <= 1'b1;
      tx_done <= 1'b0;
      sh <= '0;
      bidx <= '0;
    end else begin
      state <= ns;
      tx <= tx_n;
      tx_ready <= ns == IDLE;
      tx_done <= done_n;
      sh <= (tx_valid && tx_ready) ? tx_data : (state == DATA && tick) ? sh >> 1 : sh;
      bidx <= (ns != state) ? '0 : (state == DATA && tick) ? bidx + 1'b1 : bidx;
    end
  always_comb begin
    ns = state;
    case (state)
      IDLE:    ns = (tx_valid && tx_ready) ? START : IDLE;
      START:   ns = tick ? DATA : START;
      DATA:    ns = (tick && last_bit) ? STOP : DATA;
      STOP:    ns = tick ? IDLE : STOP;
      default: ns = IDLE;
    endcase
  end
  // tx is registered, so it is computed from the bit that will be on the line next cycle
  always_comb begin
    tx_n = ns == START ? 1'b0 : ns == DATA ? ((state == DATA && tick) ? sh[1] : sh[0]) : 1'b1;
    done_n = state == STOP && near;
  end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: three serial_tx configurations driven in parallel and compared cycle by cycle to a frame-queue model
module tb_serial_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid = 1'b0;
  logic [7:0] data = 8'h00;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int W = g == 0 ? 8 : 5;
    localparam int C = g == 0 ? 4 : g == 1 ? 2 : 16;
    logic rdy, tx, done;
    bit q[$];
    bit e_tx = 1'b1, e_rdy = 1'b1, e_done = 1'b0;
    serial_tx #(.DATA_W(W), .CLKS_PER_BIT(C)) dut (
      .clk(clk), .rst_n(rst_n), .tx_valid(valid), .tx_data(data[W-1:0]),
      .tx_ready(rdy), .tx(tx), .tx_done(done)
    );
    // a frame is the whole expected line waveform, one entry per clock cycle
    always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        q.delete();
        e_tx = 1'b1; e_rdy = 1'b1; e_done = 1'b0;
      end else begin
        if (e_rdy && valid) begin
          for (int k = 0; k < C; k++) q.push_back(1'b0);
          for (int b = 0; b < W; b++)
            for (int k = 0; k < C; k++) q.push_back(data[b]);
          for (int k = 0; k < C; k++) q.push_back(1'b1);
        end
        e_rdy = q.size() == 0;
        e_tx = 1'b1;
        e_done = 1'b0;
        if (q.size() > 0) begin
          e_tx = q.pop_front();
          e_done = q.size() == 0;
        end
      end
    always @(negedge clk) begin
      check($sformatf("tx%0d", g), tx, e_tx);
      check($sformatf("ready%0d", g), rdy, e_rdy);
      check($sformatf("done%0d", g), done, e_done);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cycles(3);
    check("rst_ready", u[0].rdy, 1);
    check("rst_tx", u[0].tx, 1);
    rst_n = 1'b1;
    cycles(1);
    data = 8'hA5; valid = 1'b1;
    cycles(1);
    valid = 1'b0;
    cycles(130);
    data = 8'h00; valid = 1'b1;
    cycles(1);
    data = 8'hFF;
    cycles(90);
    valid = 1'b0;
    cycles(130);
    data = 8'h81; valid = 1'b1;
    cycles(1);
    valid = 1'b0; data = 8'h3C;
    cycles(10);
    valid = 1'b1;
    cycles(1);
    valid = 1'b0;
    cycles(130);
    check("idle_ready", u[0].rdy, 1);
    check("idle_tx", u[0].tx, 1);
    data = 8'h55; valid = 1'b1;
    cycles(1);
    valid = 1'b0;
    cycles(16);
    check("bit3_tx", u[0].tx, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_tx", u[0].tx, 1);
    check("async_ready", u[0].rdy, 1);
    check("async_done", u[0].done, 0);
    cycles(2);
    data = 8'h0F; valid = 1'b1; rst_n = 1'b1;
    cycles(1);
    valid = 1'b0;
    cycles(130);
    repeat (60) begin
      data = 8'($urandom);
      valid = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 20) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      cycles($urandom_range(1, 30));
    end
    valid = 1'b0;
    cycles(130);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
